// File: rtl/ascii_scroller.sv
// ascii_scroller: buffers a short ASCII message written byte by byte and
// replays it one character per step to the 7-segment decoder, with a blank
// step between repetitions. Lowercase letters are folded to uppercase on write.
module ascii_scroller #(
    parameter int MSG_DEPTH   = 16,
    parameter int STEP_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_char,
    input  logic                         clr,
    input  logic                         run,
    input  logic [1:0]                   rate,
    output logic [7:0]                   char,
    output logic                         char_stb,
    output logic                         wrap,
    output logic [$clog2(MSG_DEPTH):0]   len,
    output logic                         full,
    output logic                         busy
);

    localparam int IW = $clog2(MSG_DEPTH);
    localparam int LW = IW + 1;
    // Room for STEP_CYCLES << 3, the longest programmable step.
    localparam int CW = $clog2(STEP_CYCLES) + 4;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t          state, state_d;
    logic [7:0]      msg_buf [MSG_DEPTH];
    logic [IW-1:0]   idx, idx_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [CW-1:0]   period;
    logic            step_end;
    logic            last_char;
    logic [7:0]      char_d;
    logic            char_stb_d;
    logic            wrap_d;
    logic [LW-1:0]   len_d;
    logic            full_d;
    logic            busy_d;
    logic            wr_do;

    // The decoder only knows 'A'-'Z', so 'a'-'z' are stored as uppercase.
    function automatic logic [7:0] fold_case(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A)
            return c - 8'h20;
        return c;
    endfunction

    // rate is read live, so a shorter period ends an overdue step at once;
    // hence the >= rather than == compare.
    assign period    = CW'(STEP_CYCLES) << rate;
    assign step_end  = (cnt >= period - CW'(1));
    assign last_char = ((LW'(idx) + LW'(1)) == len);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state and next-output logic; priority clr > run=0 > step > write.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d    = state;
        idx_d      = idx;
        cnt_d      = cnt;
        char_d     = char;
        char_stb_d = 1'b0;
        wrap_d     = 1'b0;
        len_d      = len;
        wr_do      = 1'b0;

        if (clr) begin
            state_d = IDLE;
            len_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
            char_d  = 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (run && len != '0) begin
                        state_d    = SHOW;
                        idx_d      = '0;
                        cnt_d      = '0;
                        char_d     = msg_buf[0];
                        char_stb_d = 1'b1;
                    end else if (wr_en && !full) begin
                        wr_do = 1'b1;
                        len_d = len + LW'(1);
                    end
                end
                SHOW, GAP: begin
                    if (!run) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                        char_d  = 8'h00;
                    end else if (step_end) begin
                        cnt_d      = '0;
                        char_stb_d = 1'b1;
                        if (state == GAP) begin
                            state_d = SHOW;
                            idx_d   = '0;
                            char_d  = msg_buf[0];
                        end else if (last_char) begin
                            state_d = GAP;
                            char_d  = 8'h00;
                            wrap_d  = 1'b1;
                        end else begin
                            idx_d  = idx + IW'(1);
                            char_d = msg_buf[idx + IW'(1)];
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        full_d = (len_d == LW'(MSG_DEPTH));
    end

    // Datapath and output registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            cnt      <= '0;
            char     <= 8'h00;
            char_stb <= 1'b0;
            wrap     <= 1'b0;
            len      <= '0;
            full     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            idx      <= idx_d;
            cnt      <= cnt_d;
            char     <= char_d;
            char_stb <= char_stb_d;
            wrap     <= wrap_d;
            len      <= len_d;
            full     <= full_d;
            busy     <= busy_d;
        end
    end

    // Message buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; len alone says which entries are valid,
        // and leaving the array unreset lets it map onto plain RAM.
        if (wr_do)
            msg_buf[len[IW-1:0]] <= fold_case(wr_char);
    end

endmodule

// File: tb/tb_ascii_scroller.sv
// Directed self-checking bench for ascii_scroller with a 4-entry buffer and
// a 4-cycle base step.
module tb_ascii_scroller;

    localparam int DEPTH = 4;
    localparam int STEP  = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_char;
    logic       clr;
    logic       run;
    logic [1:0] rate;
    logic [7:0] char;
    logic       char_stb;
    logic       wrap;
    logic [2:0] len;
    logic       full;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ascii_scroller #(
        .MSG_DEPTH  (DEPTH),
        .STEP_CYCLES(STEP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_char (wr_char),
        .clr     (clr),
        .run     (run),
        .rate    (rate),
        .char    (char),
        .char_stb(char_stb),
        .wrap    (wrap),
        .len     (len),
        .full    (full),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] c);
        wr_en   = 1'b1;
        wr_char = c;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic chk_step(input string tag, input logic [7:0] c, input logic stb, input logic wr);
        check({tag, "_char"}, char, c);
        check({tag, "_stb"}, char_stb, stb);
        check({tag, "_wrap"}, wrap, wr);
    endtask

    logic [7:0] seq2 [5];

    initial begin
        seq2 = '{8'h48, 8'h49, 8'h21, 8'h00, 8'h48};
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_char = 8'h00;
        clr     = 1'b0;
        run     = 1'b0;
        rate    = 2'd0;
        tick();
        tick();

        // 1: reset state, then run with an empty buffer
        chk_step("rst", 8'h00, 1'b0, 1'b0);
        check("rst_len", len, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        tick();
        check("empty_run_busy", busy, 0);
        check("empty_run_char", char, 8'h00);
        run = 1'b0;

        // 2: "hi!" at rate 0, each step 4 cycles, wrap only on the blank
        wr(8'h68);
        wr(8'h69);
        wr(8'h21);
        check("hi_len", len, 3);
        run = 1'b1;
        tick();
        check("hi_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            chk_step("hi_new", seq2[k], 1'b1, seq2[k] == 8'h00);
            for (int j = 1; j < ((k == 4) ? 2 : 4); j++) begin
                tick();
                chk_step("hi_hold", seq2[k], 1'b0, 1'b0);
            end
            if (k < 4)
                tick();
        end

        // 5: drop run mid-character, then restart with a full-length step
        run = 1'b0;
        tick();
        chk_step("stop", 8'h00, 1'b0, 1'b0);
        check("stop_busy", busy, 0);
        check("stop_len", len, 3);
        run = 1'b1;
        tick();
        chk_step("restart", 8'h48, 1'b1, 1'b0);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk_step("restart_hold", 8'h48, 1'b0, 1'b0);
        end
        tick();
        chk_step("restart_next", 8'h49, 1'b1, 1'b0);
        run = 1'b0;
        tick();

        // 3: fill past capacity; the fifth byte is dropped
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_len", len, 0);
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        check("fill3_len", len, 3);
        check("fill3_full", full, 0);
        wr(8'h44);
        check("fill4_len", len, 4);
        check("fill4_full", full, 1);
        wr(8'h45);
        check("fill5_len", len, 4);

        // 4: rate 2 gives 16-cycle steps; writes while scrolling are ignored
        rate = 2'd2;
        run  = 1'b1;
        tick();
        chk_step("r2_a", 8'h41, 1'b1, 1'b0);
        for (int j = 1; j < 16; j++) begin
            wr_en   = (j <= 3);
            wr_char = 8'h58;
            tick();
            chk_step("r2_a_hold", 8'h41, 1'b0, 1'b0);
        end
        wr_en = 1'b0;
        check("scroll_wr_len", len, 4);
        tick();
        chk_step("r2_b", 8'h42, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++)
            tick();
        chk_step("r2_b_cnt10", 8'h42, 1'b0, 1'b0);
        rate = 2'd0;
        tick();
        chk_step("rate_cut_c", 8'h43, 1'b1, 1'b0);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk_step("r0_c_hold", 8'h43, 1'b0, 1'b0);
        end
        tick();
        chk_step("r0_d", 8'h44, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++)
            tick();
        chk_step("r0_gap", 8'h00, 1'b1, 1'b1);
        for (int j = 0; j < 4; j++)
            tick();
        chk_step("r0_again_a", 8'h41, 1'b1, 1'b0);

        // 6: clr with a simultaneous write during SHOW
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_char = 8'h5A;
        tick();
        clr   = 1'b0;
        wr_en = 1'b0;
        chk_step("clr_show", 8'h00, 1'b0, 1'b0);
        check("clr_show_len", len, 0);
        check("clr_show_full", full, 0);
        check("clr_show_busy", busy, 0);

        // single lowercase character folds to 'Q' and repeats with a gap
        wr(8'h71);
        check("one_len", len, 1);
        tick();
        check("one_idle_busy", busy, 1);
        chk_step("one_q", 8'h51, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++)
            tick();
        chk_step("one_gap", 8'h00, 1'b1, 1'b1);
        check("one_gap_busy", busy, 1);
        tick();

        // reset pulse in the middle of the gap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run   = 1'b0;
        chk_step("rst_gap", 8'h00, 1'b0, 1'b0);
        check("rst_gap_len", len, 0);
        check("rst_gap_busy", busy, 0);
        check("rst_gap_full", full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
